// File: rtl/ddr3_wb_arbiter_if.sv
// Wishbone bundle between NUM_PORTS masters, the arbiter and the DDR3 controller.
// slave: arbiter view (master-side i_m_*, controller-side i_wb_*); master: environment view.
interface ddr3_wb_arbiter_if #(
  parameter int NUM_PORTS    = 3,
  parameter int WB_ADDR_BITS = 24,
  parameter int WB_DATA_BITS = 512,
  parameter int WB_SEL_BITS  = WB_DATA_BITS/8
);
  logic [NUM_PORTS-1:0]              i_m_cyc;
  logic [NUM_PORTS-1:0]              i_m_stb;
  logic [NUM_PORTS-1:0]              i_m_we;
  logic [NUM_PORTS*WB_ADDR_BITS-1:0] i_m_addr;
  logic [NUM_PORTS*WB_DATA_BITS-1:0] i_m_data;
  logic [NUM_PORTS*WB_SEL_BITS-1:0]  i_m_sel;
  logic [NUM_PORTS-1:0]              o_m_stall;
  logic [NUM_PORTS-1:0]              o_m_ack;
  logic [WB_DATA_BITS-1:0]           o_m_data;
  logic                              o_wb_cyc;
  logic                              o_wb_stb;
  logic                              o_wb_we;
  logic [WB_ADDR_BITS-1:0]           o_wb_addr;
  logic [WB_DATA_BITS-1:0]           o_wb_data;
  logic [WB_SEL_BITS-1:0]            o_wb_sel;
  logic                              i_wb_stall;
  logic                              i_wb_ack;
  logic [WB_DATA_BITS-1:0]           i_wb_data;

  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we,
    input  i_m_addr, i_m_data, i_m_sel,
    output o_m_stall, o_m_ack, o_m_data,
    output o_wb_cyc, o_wb_stb, o_wb_we,
    output o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_stall, i_wb_ack, i_wb_data
  );

  modport master (
    output i_m_cyc, i_m_stb, i_m_we,
    output i_m_addr, i_m_data, i_m_sel,
    input  o_m_stall, o_m_ack, o_m_data,
    input  o_wb_cyc, o_wb_stb, o_wb_we,
    input  o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_stall, i_wb_ack, i_wb_data
  );
endinterface

// File: rtl/ddr3_wb_arbiter.sv
// Round-robin arbiter sharing the DDR3 controller Wishbone port among NUM_PORTS masters.
// Ports: i_controller_clk, i_rst_n (async low), bus (slave modport). Macro: DDR3_ARB_FIXED_PRIORITY_EN.
module ddr3_wb_arbiter #(
  parameter int NUM_PORTS       = 3,
  parameter int WB_ADDR_BITS    = 24,
  parameter int WB_DATA_BITS    = 512,
  parameter int WB_SEL_BITS     = WB_DATA_BITS/8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int MAX_GRANT_BEATS = 16
) (
  input logic             i_controller_clk,
  input logic             i_rst_n,
  ddr3_wb_arbiter_if.slave bus
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(MAX_GRANT_BEATS + 1);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN, ABORT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [BW-1:0] beats_q, beats_d;
  logic [IW-1:0] pick, nxt_ptr;
  logic          others, quota_hit, limit;
  logic          on_bus, accept, ack_ok;
`ifndef DDR3_ARB_FIXED_PRIORITY_EN
  logic          found;
`endif

  always_comb begin
    pick = rr_ptr_q;
`ifdef DDR3_ARB_FIXED_PRIORITY_EN
    for (int i = NUM_PORTS-1; i >= 0; i--)
      if (bus.i_m_cyc[i]) pick = IW'(i);
`else
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found &&
          bus.i_m_cyc[(int'(rr_ptr_q) + i) % NUM_PORTS]) begin
        pick  = IW'((int'(rr_ptr_q) + i) % NUM_PORTS);
        found = 1'b1;
      end
    end
`endif
  end

  // Fixed priority only yields to lower-index masters.
  always_comb begin
    others = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef DDR3_ARB_FIXED_PRIORITY_EN
      if (k < int'(owner_q) && bus.i_m_cyc[k]) others = 1'b1;
`else
      if (k != int'(owner_q) && bus.i_m_cyc[k]) others = 1'b1;
`endif
    end
  end

  assign quota_hit = (beats_q == BW'(MAX_GRANT_BEATS)) && others;
  assign limit     = (outst_q == OW'(MAX_OUTSTANDING)) || quota_hit;
  assign on_bus    = (state_q == OWN) || (state_q == DRAIN);
  assign accept    = bus.o_wb_stb && !bus.i_wb_stall;
  assign ack_ok    = bus.i_wb_ack && on_bus && (outst_q != '0);
  assign nxt_ptr   = (owner_q == IW'(NUM_PORTS-1)) ?
                     '0 : owner_q + IW'(1);

  always_comb begin
    bus.o_wb_cyc  = on_bus;
    bus.o_wb_stb  = (state_q == OWN) &&
                    bus.i_m_stb[owner_q] && !limit;
    bus.o_wb_we   = bus.i_m_we[owner_q];
    bus.o_wb_addr = bus.i_m_addr[int'(owner_q)*WB_ADDR_BITS
                                 +: WB_ADDR_BITS];
    bus.o_wb_data = bus.i_m_data[int'(owner_q)*WB_DATA_BITS
                                 +: WB_DATA_BITS];
    bus.o_wb_sel  = bus.i_m_sel[int'(owner_q)*WB_SEL_BITS
                                +: WB_SEL_BITS];
    bus.o_m_data  = bus.i_wb_data;
    bus.o_m_stall = '1;
    if (state_q == OWN)
      bus.o_m_stall[owner_q] = bus.i_wb_stall || limit;
    bus.o_m_ack = '0;
    if (ack_ok) bus.o_m_ack[owner_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    outst_d  = outst_q;
    beats_d  = beats_q;
    if (accept && !ack_ok)      outst_d = outst_q + OW'(1);
    else if (!accept && ack_ok) outst_d = outst_q - OW'(1);
    if (accept && beats_q != BW'(MAX_GRANT_BEATS))
      beats_d = beats_q + BW'(1);
    unique case (state_q)
      IDLE: begin
        if (|bus.i_m_cyc) begin
          owner_d = pick;
          beats_d = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!bus.i_m_cyc[owner_q])
          state_d = (outst_q == '0) ? IDLE : ABORT;
        else if (quota_hit)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (outst_q == '0)               state_d = IDLE;
        else if (!bus.i_m_cyc[owner_q])  state_d = ABORT;
      end
      ABORT: begin
        // cyc low for this cycle aborts the controller's burst.
        outst_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_d != state_q)
      rr_ptr_d = nxt_ptr;
  end

  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      outst_q  <= '0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      outst_q  <= outst_d;
      beats_q  <= beats_d;
    end
  end
endmodule

// File: doc/ddr3_wb_arbiter.md
Name: ddr3_wb_arbiter

Overview:
- Shares the single Wishbone port of the DDR3 controller between NUM_PORTS pipelined Wishbone masters (for example a CPU, a DMA engine and a video scan-out engine).
- Sits between the masters and the controller's i_wb_* / o_wb_* interface; the PHY is untouched.
- Grants the bus per bus cycle, using round-robin arbitration.
- Tracks outstanding requests so acks always return to the granted master, and enforces a beat quota for fairness.

Parameters:
- NUM_PORTS, 3, number of requesting masters (2..8).
- WB_ADDR_BITS, 24, width of the controller's burst address.
- WB_DATA_BITS, 512, width of the controller's data bus.
- WB_SEL_BITS, WB_DATA_BITS/8, byte-strobe width.
- MAX_OUTSTANDING, 8, maximum number of accepted but unacked requests (power of 2).
- MAX_GRANT_BEATS, 16, number of accepted requests before the owner must yield if another master is pending.

Ports:
- i_controller_clk  in  1  controller clock; all logic is on this clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_m_cyc  in  NUM_PORTS  per-master cyc.
- i_m_stb  in  NUM_PORTS  per-master stb.
- i_m_we  in  NUM_PORTS  per-master write enable.
- i_m_addr  in  NUM_PORTS*WB_ADDR_BITS  packed addresses; master k occupies slice k.
- i_m_data  in  NUM_PORTS*WB_DATA_BITS  packed write data.
- i_m_sel  in  NUM_PORTS*WB_SEL_BITS  packed byte strobes.
- o_m_stall  out  NUM_PORTS  per-master stall.
- o_m_ack  out  NUM_PORTS  per-master ack.
- o_m_data  out  WB_DATA_BITS  read data, broadcast to all masters; valid only with the master's own ack.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  to the controller.
- o_wb_addr  out  WB_ADDR_BITS  to the controller.
- o_wb_data  out  WB_DATA_BITS  to the controller.
- o_wb_sel  out  WB_SEL_BITS  to the controller.
- i_wb_stall, i_wb_ack  in  1  from the controller.
- i_wb_data  in  WB_DATA_BITS  from the controller.

Behaviour:
- Reset (asynchronous, all outputs):
  - state=IDLE, owner=0, rr_ptr=0, outstanding=0, beats=0.
  - o_wb_cyc=0, o_wb_stb=0.
  - o_m_stall all 1, o_m_ack all 0.
- States: IDLE, OWN, DRAIN, ABORT.
- IDLE:
  - o_wb_cyc=0 and all stalls=1.
  - If any i_m_cyc is high, register owner = first requester at or after rr_ptr (wrapping modulo NUM_PORTS), clear beats, go to OWN.
  - The grant takes effect 1 cycle after cyc is seen.
- Datapath muxing:
  - In OWN and DRAIN, o_wb_cyc=1 and the o_wb_* data fields are combinationally muxed from master `owner`.
- Strobe and stall in OWN:
  - o_wb_stb = i_m_stb[owner] & ~limit.
  - o_m_stall[owner] = i_wb_stall | limit.
  - limit = (outstanding==MAX_OUTSTANDING) | quota_hit.
  - quota_hit = (beats==MAX_GRANT_BEATS) & (another master's cyc is high).
  - Non-owners always see stall=1.
- Accepted request: o_wb_stb & ~i_wb_stall.
  - An accepted request increments outstanding and beats (beats saturates at MAX_GRANT_BEATS).
- Ack:
  - i_wb_ack with outstanding>0 decrements outstanding.
  - It drives o_m_ack[owner]=1 combinationally in the same cycle.
  - An accept and an ack in the same cycle leave outstanding unchanged.
  - An ack arriving with outstanding==0, or in IDLE or ABORT, is dropped; no o_m_ack is asserted.
- OWN transitions:
  - Owner cyc drops with outstanding==0 → IDLE.
  - Owner cyc drops with outstanding>0 → ABORT.
  - quota_hit → DRAIN.
- DRAIN:
  - o_wb_stb=0 and the owner is stalled; acks are still routed to the owner.
  - outstanding==0 → IDLE.
  - Owner cyc drops → ABORT.
- ABORT:
  - o_wb_cyc=0 for exactly 1 cycle; this is the controller's bus abort.
  - Clear outstanding, → IDLE.
- rr_ptr update: on every transition out of OWN/DRAIN/ABORT, rr_ptr = owner+1, wrapping to 0 after NUM_PORTS-1.
- A master whose cyc drops while it is not the owner has no effect.
- Reset asserted mid-transaction returns everything to the reset values immediately; the controller sees cyc=0.
- Invariant: outstanding never exceeds MAX_OUTSTANDING and never underflows.

Optional Feature:
- Macro: DDR3_ARB_FIXED_PRIORITY_EN.
- Defined: the IDLE grant goes to the lowest-index master with cyc high, and rr_ptr is ignored. quota_hit only counts pending masters with a lower index than the owner, so higher-index masters never pre-empt.
- Undefined: the round-robin behaviour described above.

Test Plan:
- Single master 0 issues 4 reads, controller stall=0 with ack 3 cycles later → grant 1 cycle after cyc; 4 acks only on o_m_ack[0]; outstanding returns to 0; state IDLE after cyc drops.
- Masters 0 and 1 both hold cyc and stream continuously, MAX_GRANT_BEATS=16 → master 0 gets 16 accepts, then DRAIN until outstanding=0, then master 1 is granted; grants alternate 0,1,0.
- Controller withholds acks → the owner stalls after exactly 8 accepts; the first ack releases 1 more accept in the following cycle.
- Owner drops cyc with 3 outstanding → o_wb_cyc=0 for 1 cycle (ABORT); 3 late acks are not forwarded to any master; the next master is granted.
- Spurious i_wb_ack in IDLE, and ack+accept in the same cycle → no o_m_ack asserted in IDLE; outstanding unchanged in the ack+accept case.
- With DDR3_ARB_FIXED_PRIORITY_EN, masters 1 and 2 owning and master 0 requesting → master 0 wins every IDLE arbitration; master 2 never pre-empts master 1.
